// File: rtl/trace_pkg.sv
// Shared types for the DPLL assignment trail: entry layout, entry type codes, FSM states.
package trace_pkg;

    localparam int unsigned TRACE_VAR_W = 10;

    localparam logic TYPE_DEC    = 1'b0;
    localparam logic TYPE_FORCED = 1'b1;

    typedef struct packed {
        logic [TRACE_VAR_W-1:0] var_idx;
        logic                   val;
        logic                   typ;
    } trace_entry_t;

    typedef enum logic {
        IDLE,
        UNWIND
    } trace_state_t;

endpackage

// File: rtl/lifo_mem.sv
// Trail storage: one write port, one registered read port that always presents the stack top.
module lifo_mem #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 12
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_q;

    // Any write always lands on the new top, so forwarding the write data keeps rd_q current.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rd_q <= we_i ? wdata_i : mem_q[raddr_i];
    end

    assign rdata_o = rd_q;

endmodule

// File: rtl/trace_table.sv
// LIFO trail of DPLL assignments with a built-in backtrack engine.
// Optional TRACE_LEVEL_CNT_EN adds the dec_level output (number of decisions on the trail).
module trace_table
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned VAR_W = TRACE_VAR_W,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [VAR_W-1:0] push_var,
    input  logic             push_val,
    input  logic             push_type,
    input  logic             pop,
    input  logic             clear,
    output logic             pop_valid,
    output logic [VAR_W-1:0] pop_var,
    output logic             pop_val,
    output logic             pop_type,
    input  logic             bt_start,
    output logic             unwind_valid,
    output logic [VAR_W-1:0] unwind_var,
    output logic             bt_done,
    output logic             bt_found,
    output logic [VAR_W-1:0] bt_var,
    output logic             bt_val,
    output logic             busy,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
`ifdef TRACE_LEVEL_CNT_EN
    ,
    output logic [CNT_W-1:0] dec_level
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = VAR_W + 2;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    trace_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             pv_q, pv_d;
    logic [EW-1:0]    pent_q, pent_d;
    logic             bte_q, bte_d;

    logic             we;
    logic [AW-1:0]    waddr, raddr;
    logic [EW-1:0]    wdata, top;
    logic             is_empty, is_full;

    lifo_mem #(.DEPTH(DEPTH), .WIDTH(EW)) u_mem (
        .clk_i   (clock),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (top)
    );

    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == CNT_W'(DEPTH));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        udf_d        = udf_q;
        pv_d         = 1'b0;
        pent_d       = pent_q;
        bte_d        = 1'b0;
        we           = 1'b0;
        waddr        = AW'(cnt_q);
        wdata        = {push_var, push_val, push_type};
        unwind_valid = 1'b0;
        unwind_var   = '0;
        bt_done      = bte_q;
        bt_found     = 1'b0;
        bt_var       = '0;
        bt_val       = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    udf_d = 1'b0;
                end else if (bt_start) begin
                    if (is_empty) bte_d = 1'b1;
                    else          state_d = UNWIND;
                end else if (pop && !is_empty) begin
                    pv_d   = 1'b1;
                    pent_d = top;
                    if (push) begin
                        we    = 1'b1;
                        waddr = AW'(cnt_q - ONE);
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end else begin
                    if (pop) udf_d = 1'b1;
                    if (push) begin
                        if (is_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            we    = 1'b1;
                            cnt_d = cnt_q + ONE;
                        end
                    end
                end
            end
            UNWIND: begin
                unwind_valid = 1'b1;
                unwind_var   = top[EW-1:2];
                cnt_d        = cnt_q - ONE;
                if (top[0] == TYPE_DEC) begin
                    bt_done  = 1'b1;
                    bt_found = 1'b1;
                    bt_var   = top[EW-1:2];
                    bt_val   = top[1];
                    state_d  = IDLE;
                end else if (cnt_q == ONE) begin
                    bt_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        raddr = AW'(cnt_d - ONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            pv_q    <= 1'b0;
            pent_q  <= '0;
            bte_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            pv_q    <= pv_d;
            pent_q  <= pent_d;
            bte_q   <= bte_d;
        end
    end

    assign pop_valid = pv_q;
    assign pop_var   = pent_q[EW-1:2];
    assign pop_val   = pent_q[1];
    assign pop_type  = pent_q[0];
    assign busy      = (state_q == UNWIND);
    assign empty     = is_empty;
    assign full      = is_full;
    assign count     = cnt_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

`ifdef TRACE_LEVEL_CNT_EN
    logic [CNT_W-1:0] lvl_q, lvl_d;
    logic             lvl_inc, lvl_dec;

    assign lvl_inc = we && (push_type == TYPE_DEC);
    assign lvl_dec = (pv_d || unwind_valid) && (top[0] == TYPE_DEC);

    always_comb begin
        lvl_d = lvl_q;
        if (state_q == IDLE && clear) lvl_d = '0;
        else                          lvl_d = lvl_q + CNT_W'(lvl_inc) - CNT_W'(lvl_dec);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) lvl_q <= '0;
        else          lvl_q <= lvl_d;
    end

    assign dec_level = lvl_q;
`endif

endmodule

// File: tb/tb_trace_table.sv
// Randomized bench for trace_table against a queue-based trail model.
module tb_trace_table;

    localparam int DEPTH = 16;
    localparam int VAR_W = 10;
    localparam int CNT_W = 5;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             push, push_val, push_type, pop, clear, bt_start;
    logic [VAR_W-1:0] push_var;
    logic             pop_valid, pop_val, pop_type;
    logic [VAR_W-1:0] pop_var, unwind_var, bt_var;
    logic             unwind_valid, bt_done, bt_found, bt_val;
    logic             busy, empty, full, overflow, underflow;
    logic [CNT_W-1:0] count;
`ifdef TRACE_LEVEL_CNT_EN
    logic [CNT_W-1:0] dec_level;
`endif

    trace_table #(.DEPTH(DEPTH), .VAR_W(VAR_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .push(push), .push_var(push_var), .push_val(push_val), .push_type(push_type),
        .pop(pop), .clear(clear),
        .pop_valid(pop_valid), .pop_var(pop_var), .pop_val(pop_val), .pop_type(pop_type),
        .bt_start(bt_start), .unwind_valid(unwind_valid), .unwind_var(unwind_var),
        .bt_done(bt_done), .bt_found(bt_found), .bt_var(bt_var), .bt_val(bt_val),
        .busy(busy), .empty(empty), .full(full), .count(count),
        .overflow(overflow), .underflow(underflow)
`ifdef TRACE_LEVEL_CNT_EN
        , .dec_level(dec_level)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int v;
        bit val;
        bit typ;   // 0 = decision, 1 = forced
    } ent_t;

    ent_t q[$];
    bit   m_ovf, m_udf, m_busy, m_pv, m_bte;
    ent_t m_pent;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic mreset();
        q.delete();
        m_ovf = 0; m_udf = 0; m_busy = 0; m_pv = 0; m_bte = 0;
    endtask

    task automatic compare();
        bit top_dec, done_exp;
        int lvl;
        top_dec  = m_busy && (q[$].typ == 0);
        done_exp = m_busy ? (top_dec || q.size() == 1) : m_bte;
        chk("count", count, q.size());
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_udf);
        chk("busy", busy, m_busy);
        chk("pop_valid", pop_valid, m_pv);
        if (m_pv) begin
            chk("pop_var", pop_var, m_pent.v);
            chk("pop_val", pop_val, m_pent.val);
            chk("pop_type", pop_type, m_pent.typ);
        end
        chk("unwind_valid", unwind_valid, m_busy);
        if (m_busy) chk("unwind_var", unwind_var, q[$].v);
        chk("bt_done", bt_done, done_exp);
        chk("bt_found", bt_found, top_dec);
        if (top_dec) begin
            chk("bt_var", bt_var, q[$].v);
            chk("bt_val", bt_val, q[$].val);
        end
        lvl = 0;
        foreach (q[i]) if (q[i].typ == 0) lvl++;
`ifdef TRACE_LEVEL_CNT_EN
        chk("dec_level", dec_level, lvl);
`endif
    endtask

    task automatic mstep();
        ent_t e, ne;
        bit pv_n, bte_n;
        pv_n = 0; bte_n = 0;
        ne.v = int'(push_var); ne.val = push_val; ne.typ = push_type;
        if (m_busy) begin
            e = q.pop_back();
            if (e.typ == 0 || q.size() == 0) m_busy = 0;
        end else if (clear) begin
            q.delete(); m_ovf = 0; m_udf = 0;
        end else if (bt_start) begin
            if (q.size() == 0) bte_n = 1;
            else               m_busy = 1;
        end else if (pop && q.size() > 0) begin
            m_pent = q.pop_back();
            pv_n = 1;
            if (push) q.push_back(ne);
        end else begin
            if (pop) m_udf = 1;
            if (push) begin
                if (q.size() == DEPTH) m_ovf = 1;
                else                   q.push_back(ne);
            end
        end
        m_pv = pv_n; m_bte = bte_n;
    endtask

    task automatic tick();
        @(negedge clock);
        compare();
        @(posedge clock);
        if (!reset_n) mreset();
        else          mstep();
        #1;
    endtask

    task automatic drive(input bit p, input int v, input bit val, input bit typ,
                         input bit po, input bit cl, input bit bt);
        push = p; push_var = VAR_W'(v); push_val = val; push_type = typ;
        pop = po; clear = cl; bt_start = bt;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        push = 0; push_var = '0; push_val = 0; push_type = 0;
        pop = 0; clear = 0; bt_start = 0;
        mreset();
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        idle(2);
        reset_n = 1'b1;
        idle(1);

        // decision found after two forced entries
        drive(1, 3, 1, 0, 0, 0, 0);
        drive(1, 5, 0, 1, 0, 0, 0);
        drive(1, 7, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(4);
        chk("bt2_count", count, 0);

        // only forced entries: exhausted trail
        drive(1, 2, 0, 1, 0, 0, 0);
        drive(1, 4, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(3);
        chk("bt3_empty", empty, 1);

        // fill and overflow
        for (int i = 0; i <= DEPTH; i++) drive(1, 100 + i, i % 2, 1, 0, 0, 0);
        chk("fill_full", full, 1);
        chk("fill_ovf", overflow, 1);
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(1);
        chk("fill_top", pop_var, 100 + DEPTH - 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        idle(1);

        // replace the top with simultaneous push and pop
        drive(1, 9, 1, 0, 0, 0, 0);
        drive(1, 6, 0, 1, 1, 0, 0);
        idle(1);
        chk("rep_var", pop_var, 9);
        drive(0, 0, 0, 0, 1, 0, 0);
        idle(1);
        chk("rep_pop", pop_var, 6);

        // empty pop and empty backtrack
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(2);
        chk("emp_udf", underflow, 1);
        drive(1, 11, 0, 0, 0, 0, 0);
        drive(1, 12, 1, 0, 0, 0, 0);
        drive(1, 13, 0, 1, 0, 0, 0);
        idle(1);
        drive(0, 0, 0, 0, 0, 1, 0);
        idle(1);

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) < 50, int'($urandom_range(0, 1023)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 99) < 35, $urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < 5);
        end
        idle(DEPTH + 2);

        // asynchronous reset in the middle of an unwind
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) drive(1, 20 + i, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", bt_done, 0);
        chk("mid_rst_unwind", unwind_valid, 0);
        chk("mid_rst_pv", pop_valid, 0);
        mreset();
        idle(2);
        reset_n = 1'b1;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
